sram_scan_sequencer: RTL

// - Sequences the scan-chain SRAM test harness (scan clock, scan data, scan enable, sram_load, csb) from one parallel command.
// - Sits in the user project between the LA/Wishbone command source and the harness pads that a bench otherwise drives by hand.
// - Per command: shift a {we, addr, wdata} frame into the chain and pulse sram_load; on reads, also shift the captured data word back out.

---
 rtl/sram_scan_pkg.sv | 25 ++
 rtl/scan_phase_gen.sv | 37 +++
 rtl/sram_scan_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sram_scan_pkg.sv
// Shared definitions for the scan-chain SRAM sequencer: FSM states and frame geometry.
package sram_scan_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StShiftIn,
        StLoad,
        StShiftOut,
        StResp
    } state_e;

    // Frame layout, MSB first on the chain: {we, addr, data}
    function automatic int unsigned chain_w(int unsigned addr_w, int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

    function automatic int unsigned frame_we_pos(int unsigned addr_w, int unsigned data_w);
        return addr_w + data_w;
    endfunction

    function automatic int unsigned frame_addr_lsb(int unsigned data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/scan_phase_gen.sv
// Scan clock phase divider: each phase lasts HALF_DIV cycles, low phase first after restart.
module scan_phase_gen #(
    parameter int unsigned HALF_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic phase,
    output logic tick,
    output logic rise
);

    localparam int unsigned CntW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(HALF_DIV - 1);

    logic [CntW-1:0] cnt_q;
    logic            phase_q;

    // tick marks the last cycle of the current phase
    assign phase = phase_q;
    assign tick  = (cnt_q == LastCnt);
    assign rise  = tick && !phase_q;

    // Phase counter; restart pins it to the start of a low phase
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (tick) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/sram_scan_sequencer.sv
// Turns one parallel SRAM command into scan-chain shift/load/shift-out sequences.
module sram_scan_sequencer #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned HALF_DIV = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              scan_clk,
    output logic              scan_en,
    output logic              scan_in,
    input  logic              scan_out,
    output logic              sram_load,
    output logic              sram_csb,
    output logic              busy
);

    import sram_scan_pkg::*;

    localparam int unsigned ChainW  = chain_w(ADDR_W, DATA_W);
    localparam int unsigned WePos   = frame_we_pos(ADDR_W, DATA_W);
    localparam int unsigned AddrLsb = frame_addr_lsb(DATA_W);
    localparam int unsigned CntW    = $clog2(ChainW + 1);
    localparam logic [CntW-1:0] LastInBit  = CntW'(ChainW - 1);
    localparam logic [CntW-1:0] LastOutBit = CntW'(DATA_W - 1);

    state_e              state_q;
    logic                prime_q;
    logic                we_q;
    logic [ChainW-1:0]   frame_q;
    logic [CntW-1:0]     bit_cnt_q;
    logic [DATA_W-1:0]   rd_sh_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                scan_clk_q;
    logic                scan_en_q;
    logic                scan_in_q;
    logic                sram_load_q;
    logic                sram_csb_q;

    logic [ChainW-1:0]   cmd_frame;
    logic                leave;
    logic                restart;
    logic                ph_phase;
    logic                ph_tick;
    logic                ph_rise;
    logic                ph_fall;

    assign ph_fall   = ph_tick && ph_phase;
    assign busy      = (state_q != StIdle);
    assign cmd_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign scan_clk  = scan_clk_q;
    assign scan_en   = scan_en_q;
    assign scan_in   = scan_in_q;
    assign sram_load = sram_load_q;
    assign sram_csb  = sram_csb_q;

    scan_phase_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_phase (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .restart (restart),
        .phase   (ph_phase),
        .tick    (ph_tick),
        .rise    (ph_rise)
    );

    // Build the outgoing frame; reads shift zeros in the data field
    always_comb begin
        cmd_frame                      = '0;
        cmd_frame[WePos]               = cmd_we;
        cmd_frame[AddrLsb +: ADDR_W]   = cmd_addr;
        if (cmd_we) begin
            cmd_frame[DATA_W-1:0] = cmd_wdata;
        end
    end

    // Detect state exits so the divider restarts on every state entry
    always_comb begin
        case (state_q)
            StShiftIn:  leave = !prime_q && ph_fall && (bit_cnt_q == LastInBit);
            StLoad:     leave = ph_fall;
            StShiftOut: leave = ph_fall && (bit_cnt_q == LastOutBit);
            default:    leave = 1'b0;
        endcase
        restart = leave || prime_q || (state_q == StIdle) || (state_q == StResp);
    end

    // Sequencer FSM with registered harness and response outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            prime_q     <= 1'b0;
            we_q        <= 1'b0;
            frame_q     <= '0;
            bit_cnt_q   <= '0;
            rd_sh_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            scan_clk_q  <= 1'b0;
            scan_en_q   <= 1'b0;
            scan_in_q   <= 1'b0;
            sram_load_q <= 1'b0;
            sram_csb_q  <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        state_q   <= StShiftIn;
                        // One setup cycle lets the divider restart with the MSB already driven
                        prime_q   <= 1'b1;
                        we_q      <= cmd_we;
                        scan_en_q <= 1'b1;
                        scan_in_q <= cmd_frame[ChainW-1];
                        frame_q   <= {cmd_frame[ChainW-2:0], 1'b0};
                        bit_cnt_q <= '0;
                    end
                end
                StShiftIn: begin
                    if (prime_q) begin
                        prime_q <= 1'b0;
                    end else if (ph_rise) begin
                        scan_clk_q <= 1'b1;
                    end else if (ph_fall) begin
                        scan_clk_q <= 1'b0;
                        if (bit_cnt_q == LastInBit) begin
                            state_q     <= StLoad;
                            bit_cnt_q   <= '0;
                            scan_en_q   <= 1'b0;
                            scan_in_q   <= 1'b0;
                            sram_load_q <= 1'b1;
                            sram_csb_q  <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CntW'(1);
                            scan_in_q <= frame_q[ChainW-1];
                            frame_q   <= {frame_q[ChainW-2:0], 1'b0};
                        end
                    end
                end
                StLoad: begin
                    if (ph_rise) begin
                        scan_clk_q <= 1'b1;
                    end else if (ph_fall) begin
                        scan_clk_q  <= 1'b0;
                        sram_load_q <= 1'b0;
                        sram_csb_q  <= 1'b1;
                        if (we_q) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q   <= StShiftOut;
                            scan_en_q <= 1'b1;
                            rd_sh_q   <= '0;
                        end
                    end
                end
                StShiftOut: begin
                    if (ph_rise) begin
                        scan_clk_q <= 1'b1;
                        // Chain output is sampled before the harness shifts on this rise
                        rd_sh_q    <= {rd_sh_q[DATA_W-2:0], scan_out};
                    end else if (ph_fall) begin
                        scan_clk_q <= 1'b0;
                        if (bit_cnt_q == LastOutBit) begin
                            state_q     <= StResp;
                            scan_en_q   <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rd_sh_q;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CntW'(1);
                        end
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
